// File: rtl/multi_add_fifo.sv
// multi_add_fifo: N-channel FIFO-buffered joiner summing all heads; define MULTI_ADD_OUT_REG_EN for a registered output stage
module multi_add_fifo #(
  parameter int W_FIFO = 8,
  parameter int D_FIFO = 8,
  parameter int N_CH = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [N_CH*W_FIFO-1:0]           up_data,
  input  logic [N_CH-1:0]                  up_valid,
  output logic [N_CH-1:0]                  up_ready,
  output logic [W_FIFO+$clog2(N_CH)-1:0]   down_data_sum,
  output logic                             down_valid_sum,
  input  logic                             down_ready_sum
);
  localparam int W_SUM = W_FIFO + $clog2(N_CH);
  localparam int AW = $clog2(D_FIFO);
  logic [W_FIFO-1:0] head [N_CH];
  logic [N_CH-1:0] ne;
  logic all_ne, pop;
  logic [W_SUM-1:0] sum;
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [W_FIFO-1:0] mem [D_FIFO];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] cnt;
    logic push;
    assign up_ready[i] = !rst && cnt != (AW+1)'(D_FIFO);
    assign push = up_valid[i] & up_ready[i];
    assign ne[i] = cnt != '0;
    assign head[i] = mem[rd_ptr];
    always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= up_data[i*W_FIFO +: W_FIFO];
    always_ff @(posedge clk)
      if (rst) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt <= '0;
      end else begin
        wr_ptr <= wr_ptr + AW'(push);
        rd_ptr <= rd_ptr + AW'(pop);
        cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
      end
  end
  assign all_ne = &ne;
  always_comb begin
    sum = '0;
    for (int k = 0; k < N_CH; k++) sum = sum + W_SUM'(head[k]);
  end
`ifdef MULTI_ADD_OUT_REG_EN
  logic out_valid;
  logic [W_SUM-1:0] out_data;
  assign pop = all_ne & (!out_valid | down_ready_sum);
  always_ff @(posedge clk)
    if (rst) out_valid <= 1'b0;
    else if (pop) begin
      out_valid <= 1'b1;
      out_data <= sum;
    end else if (down_ready_sum) out_valid <= 1'b0;
  assign down_valid_sum = out_valid;
  assign down_data_sum = out_data;
`else
  assign pop = all_ne & down_ready_sum;
  assign down_valid_sum = all_ne;
  assign down_data_sum = sum;
`endif
endmodule

// File: tb/tb_multi_add_fifo.sv
// tb_multi_add_fifo: table vectors, directed corner sequences and a queue scoreboard for multi_add_fifo
module tb_multi_add_fifo;
  localparam int W = 8, D = 8, N = 3, WS = 10;
`ifdef MULTI_ADD_OUT_REG_EN
  localparam int LAT = 2, EXTRA = 1;
`else
  localparam int LAT = 1, EXTRA = 0;
`endif
  logic clk = 0, rst = 1;
  logic [N*W-1:0] up_data = '0;
  logic [N-1:0] up_valid = '0, up_ready;
  logic [WS-1:0] down_data_sum;
  logic down_valid_sum, down_ready_sum = 1'b1;
  int checks = 0, errors = 0;
  logic [W-1:0] q0[$], q1[$], q2[$];
  logic [WS-1:0] exp_q[$];

  multi_add_fifo #(.W_FIFO(W), .D_FIFO(D), .N_CH(N)) dut (
    .clk(clk), .rst(rst), .up_data(up_data), .up_valid(up_valid), .up_ready(up_ready),
    .down_data_sum(down_data_sum), .down_valid_sum(down_valid_sum), .down_ready_sum(down_ready_sum));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Output side is checked before this cycle's pushes are booked: no bypass exists.
  always @(negedge clk) begin
    if (rst) begin
      q0.delete(); q1.delete(); q2.delete(); exp_q.delete();
    end else begin
      if (down_valid_sum && down_ready_sum) begin
        if (exp_q.size() == 0) chk("sb_underflow", 1, 0);
        else chk("sb_sum", 32'(down_data_sum), 32'(exp_q.pop_front()));
      end
      if (up_valid[0] && up_ready[0]) q0.push_back(up_data[0 +: W]);
      if (up_valid[1] && up_ready[1]) q1.push_back(up_data[W +: W]);
      if (up_valid[2] && up_ready[2]) q2.push_back(up_data[2*W +: W]);
      while (q0.size() > 0 && q1.size() > 0 && q2.size() > 0)
        exp_q.push_back(WS'(q0.pop_front()) + WS'(q1.pop_front()) + WS'(q2.pop_front()));
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    step(); rst = 1; up_valid = '0;
    step(); rst = 0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    @(negedge clk);
    while (!down_valid_sum && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("wait_valid", 32'(down_valid_sum), 1);
  endtask

  task automatic drain();
    int n = 0;
    up_valid = '0;
    down_ready_sum = 1;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  typedef struct { logic [W-1:0] a, b, c; logic [WS-1:0] s; } vec_t;
  vec_t vt[5];

  initial begin
    int n, acc, have, gaps, done;
    logic [WS-1:0] held;
    int sent[3], gap[3], rgap;
    logic acc_b[3];
    vt[0] = '{8'd255, 8'd255, 8'd255, 10'd765};
    vt[1] = '{8'd0, 8'd0, 8'd0, 10'd0};
    vt[2] = '{8'd1, 8'd2, 8'd3, 10'd6};
    vt[3] = '{8'd128, 8'd64, 8'd32, 10'd224};
    vt[4] = '{8'd200, 8'd100, 8'd50, 10'd350};
    step(); step();
    @(negedge clk);
    chk("ready_in_rst", 32'(up_ready), 0);
    step(); rst = 0;
    @(negedge clk);
    chk("rst_valid", 32'(down_valid_sum), 0);
    chk("rst_ready", 32'(up_ready), 7);

    foreach (vt[v]) begin
      step();
      up_data = {vt[v].c, vt[v].b, vt[v].a};
      up_valid = 3'b111;
      step();
      up_valid = '0;
      repeat (LAT - 1) step();
      @(negedge clk);
      chk("vec_valid", 32'(down_valid_sum), 1);
      chk("vec_sum", 32'(down_data_sum), 32'(vt[v].s));
      step();
      @(negedge clk);
      chk("vec_empty_after", 32'(down_valid_sum), 0);
    end

    do_reset();
    for (int k = 0; k < D; k++) begin
      up_data = '0;
      up_data[0 +: W] = (k == 0) ? 8'd5 : 8'(40 + k);
      up_valid = 3'b001;
      step();
    end
    up_valid = '0;
    @(negedge clk);
    chk("full_ready0", 32'(up_ready[0]), 0);
    chk("full_no_valid", 32'(down_valid_sum), 0);
    step();
    up_data = {8'd20, 8'd10, 8'd0};
    up_valid = 3'b110;
    step();
    up_valid = '0;
    wait_valid(n);
    chk("join_latency", n, LAT - 1);
    chk("join_sum", 32'(down_data_sum), 35);
`ifdef MULTI_ADD_OUT_REG_EN
    chk("ready0_after_pop", 32'(up_ready[0]), 1);
`else
    chk("ready0_before_pop", 32'(up_ready[0]), 0);
    @(negedge clk);
    chk("ready0_after_pop", 32'(up_ready[0]), 1);
`endif

    do_reset();
    down_ready_sum = 0;
    up_data = {8'd1, 8'd2, 8'd3}; up_valid = 3'b111; step();
    up_valid = 3'b011; step();
    up_valid = 3'b001; step();
    up_valid = '0;
    repeat (LAT - 1) step();
    @(negedge clk);
    chk("pending_sum", 32'(down_valid_sum), 1);
    step(); rst = 1;
    step(); rst = 0;
    @(negedge clk);
    chk("post_rst_valid", 32'(down_valid_sum), 0);
    chk("post_rst_ready", 32'(up_ready), 7);
    down_ready_sum = 1;
    up_data = {8'd30, 8'd20, 8'd10}; up_valid = 3'b111;
    step();
    up_valid = '0;
    wait_valid(n);
    chk("post_rst_sum", 32'(down_data_sum), 60);
    drain();

    do_reset();
    down_ready_sum = 0;
    acc = 0; have = 0;
    up_valid = 3'b111;
    for (int k = 0; k < 20; k++) begin
      up_data = N*W'($urandom);
      @(negedge clk);
      acc += int'(up_valid[0] & up_ready[0]);
      if (down_valid_sum) begin
        if (have != 0) chk("hold_data", 32'(down_data_sum), 32'(held));
        held = down_data_sum;
        have = 1;
      end else if (have != 0) chk("hold_valid", 0, 1);
      step();
    end
    @(negedge clk);
    chk("bp_accepts", acc, D + EXTRA);
    chk("bp_ready_low", 32'(up_ready), 0);
    drain();

    do_reset();
    gaps = 0;
    for (int k = 0; k < 1000; k++) begin
      up_data = N*W'($urandom);
      up_valid = 3'b111;
      @(negedge clk);
      if (k >= LAT && !down_valid_sum) gaps++;
      step();
    end
    chk("stream_gaps", gaps, 0);
    drain();

    do_reset();
    foreach (sent[i]) begin sent[i] = 0; gap[i] = 0; end
    rgap = 0; done = 0;
    for (int c = 0; c < 5000 && done == 0; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) acc_b[i] = up_valid[i] & up_ready[i];
      done = (sent[0] == 60 && sent[1] == 60 && sent[2] == 60 && up_valid == '0) ? 1 : 0;
      if (done == 0) begin
        step();
        for (int i = 0; i < 3; i++) begin
          if (up_valid[i] && !acc_b[i]) ;
          else if (gap[i] > 0) begin up_valid[i] = 0; gap[i]--; end
          else if (sent[i] < 60) begin
            up_valid[i] = 1; up_data[i*W +: W] = W'($urandom);
            sent[i]++; gap[i] = $urandom_range(0, 10);
          end else up_valid[i] = 0;
        end
        if (rgap > 0) begin down_ready_sum = 0; rgap--; end
        else begin down_ready_sum = 1; rgap = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : 0; end
      end
    end
    chk("skew_done", done, 1);
    drain();
    chk("skew_q_empty", q0.size() + q1.size() + q2.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
